// File: rtl/seq_mux_n.sv
// seq_mux_n: registered N-way channel mux with manual select or dwell-paced auto-scan.
// dout and ch always describe the same channel; wrap/err are one-cycle status pulses.
module seq_mux_n #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SW    = 2,
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] din,
    output logic [W-1:0]   dout,
    output logic [SW-1:0]  ch,
    output logic           wrap,
    output logic           err
);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_ch;
    logic [W-1:0]  r_dout;
    logic          r_wrap;
    logic          r_err;
    logic [W-1:0]  w_slice [N];
    logic          w_sel_ok;
    logic          w_last;
    logic          w_ch_last;
    logic [SW-1:0] w_ch_nxt;
    logic [CW-1:0] w_cnt_nxt;
    for (genvar k = 0; k < N; k++) begin : g_slice
        assign w_slice[k] = din[k*W +: W];
    end
    assign w_sel_ok  = 32'(sel) < N;
    assign w_last    = r_cnt == CW'(DWELL - 1);
    assign w_ch_last = r_ch == SW'(N - 1);
    // an out-of-range manual select keeps the current channel and just refreshes its data
    assign w_ch_nxt  = mode ? (w_last ? (w_ch_last ? '0 : r_ch + 1'b1) : r_ch)
                            : (w_sel_ok ? sel : r_ch);
    assign w_cnt_nxt = (mode && !w_last) ? r_cnt + 1'b1 : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_ch   <= '0;
            r_dout <= '0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else if (en) begin
            r_cnt  <= w_cnt_nxt;
            r_ch   <= w_ch_nxt;
            r_dout <= w_slice[w_ch_nxt];
            r_wrap <= mode && w_last && w_ch_last;
            r_err  <= !mode && !w_sel_ok;
        end else begin
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end
    end
    assign dout = r_dout;
    assign ch   = r_ch;
    assign wrap = r_wrap;
    assign err  = r_err;
endmodule

// File: doc/seq_mux_n.md
SEQ_MUX_N -- requirements
Module: seq_mux_n

Interface
REQ-001 Parameter N, default 4: number of input channels, 2..16, not necessarily a power of two.
REQ-002 Parameter W, default 8: data width per channel, 1..32.
REQ-003 Parameter SW, default 2: select/channel-index width; SHALL satisfy 2^SW >= N.
REQ-004 Parameter DWELL, default 4: cycles per channel in scan mode, 1..256.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  cycle enable; when 0, all state holds.
REQ-008 mode  input  1  0 = manual select, 1 = auto-scan.
REQ-009 sel  input  SW  manual channel select.
REQ-010 din  input  N*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W].
REQ-011 dout  output  W  registered selected data.
REQ-012 ch  output  SW  index of the channel whose data is in dout.
REQ-013 wrap  output  1  one-cycle pulse when scan advances from channel N-1 to channel 0.
REQ-014 err  output  1  one-cycle pulse on a manual select with sel >= N.

Function
REQ-015 dout, ch, wrap and err SHALL be registered outputs; latency SHALL be exactly 1 cycle from the sampled inputs.
REQ-016 An internal dwell counter cnt, 0..DWELL-1, SHALL pace the scan.
REQ-017 On an en=1 cycle, dout SHALL load the din slice of the channel loaded into ch that same cycle, so dout and ch always correspond.
REQ-018 Manual mode (mode=0), en=1, sel<N: ch<=sel; dout<=din[sel]; cnt<=0; err<=0; wrap<=0.
REQ-019 Manual mode, en=1, sel>=N: ch holds; dout<=din[ch] (refresh of the held channel); cnt<=0; err<=1 for that one cycle.
REQ-020 Scan mode (mode=1), en=1, cnt<DWELL-1: cnt<=cnt+1; ch holds; dout<=din[ch].
REQ-021 Scan mode, en=1, cnt==DWELL-1: cnt<=0; ch<=(ch==N-1)?0:ch+1; dout<=din[new ch].
REQ-022 The wrap pulse SHALL be asserted in the cycle following the N-1 -> 0 advance only.
REQ-023 DWELL=1: ch SHALL advance on every en=1 cycle.
REQ-024 Manual-to-scan switch: scan SHALL start from the current ch with cnt=0, giving a full DWELL period on that channel.
REQ-025 Scan-to-manual switch: the first en=1 manual cycle SHALL load sel immediately; cnt SHALL clear.
REQ-026 en=0: dout, ch and cnt SHALL hold; wrap and err SHALL be 0.
REQ-027 din changes while en=1 SHALL appear on dout one cycle later, with no extra pipeline stage.

Reset
REQ-028 rst_n=0 SHALL immediately force dout=0, ch=0, cnt=0, wrap=0 and err=0, independent of clk.
REQ-029 Reset deassertion mid-scan SHALL restart the scan at channel 0 with a full dwell period.
REQ-030 The first en=1 edge after reset SHALL behave as a normal cycle in the current mode.

Verification
REQ-031 Verification uses N=4, W=8, DWELL=2, and din = {8'h44, 8'h33, 8'h22, 8'h11} (ch3..ch0) unless stated.
REQ-032 Manual, en=1, sel=2 -> next cycle dout=8'h33, ch=2, err=0; then sel=0 -> dout=8'h11, ch=0.
REQ-033 Scan from reset, en=1 held -> ch sequence 0,0,1,1,2,2,3,3,0; wrap=1 exactly one cycle, the cycle ch returns to 0.
REQ-034 Parameter N=3, manual mode, ch=1, sel=3 -> err=1 for one cycle, ch stays 1, dout=din[1].
REQ-035 Scan with en=0 for 5 cycles mid-dwell -> ch, dout and cnt frozen; scan resumes where it stopped, dwell intact.
REQ-036 Scan at ch=2, rst_n pulsed low between edges -> dout=0 and ch=0 immediately; after release, ch sequence restarts 0,0,1,...
REQ-037 Manual sel=3, then switch to scan -> ch=3 for 2 cycles, then 0 with wrap=1.
